// File: rtl/fifo_pkg.sv
// Definitions shared by the sample FIFO write and read controllers.
package fifo_pkg;

  localparam int unsigned DATA_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/fifo_wr_if.sv
// FIFO write-port bundle: request/data from the writer, full/empty flags back from the FIFO.
interface fifo_wr_if #(
  parameter int unsigned DATA_W = fifo_pkg::DATA_W
);

  logic              wrreq;
  logic [DATA_W-1:0] wrdata;
  logic              full;
  logic              empty;

  modport master (output wrreq, output wrdata, input full, input empty);
  modport slave  (input wrreq, input wrdata, output full, output empty);

endinterface

// File: rtl/sample_decim.sv
// Decimation counter: after a load, qualifies one of every decim_q+1 valid strobes.
module sample_decim #(
  parameter int unsigned DECIM_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               adc_valid,
  input  logic [DECIM_W-1:0] decim_q,
  output logic               qualify
);

  logic [DECIM_W-1:0] cnt;

  assign qualify = adc_valid && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (adc_valid) begin
      cnt <= (cnt == '0) ? decim_q : cnt - DECIM_W'(1);
    end
  end

endmodule

// File: rtl/fifo_wr.sv
// Write-side controller for the sample FIFO: waits for empty, lets the flags settle,
// then streams decimated ADC samples until the FIFO reports full.
module fifo_wr #(
  parameter int unsigned DATA_W     = fifo_pkg::DATA_W,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned DECIM_W    = 16,
  parameter int unsigned CNT_W      = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  adc_data,
  input  logic               adc_valid,
  input  logic [DECIM_W-1:0] decim,
  fifo_wr_if.master          fifo,
  output logic               busy,
  output logic               frame_done,
  output logic [CNT_W-1:0]   frame_words,
  output logic [7:0]         drop_cnt
);

  import fifo_pkg::*;

  localparam int unsigned SET_W = 4;

  state_e             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [DECIM_W-1:0] decim_q;
  logic [CNT_W-1:0]   word_cnt;
  logic [DATA_W-1:0]  wrdata;
  logic               wr_pend;
  logic               wrreq;
  logic               empty_ok;
  logic               start;
  logic               in_write;
  logic               valid_w;
  logic               qualify;
  logic               take;

  // Full wins over empty when both flags are up.
  assign empty_ok = fifo.empty && !fifo.full;
  assign in_write = (state_q == ST_WRITE);
  assign valid_w  = adc_valid && in_write;
  assign take     = qualify && !fifo.full;
  assign wrreq    = wr_pend && !fifo.full;

  assign fifo.wrreq  = wrreq;
  assign fifo.wrdata = wrdata;

  sample_decim #(.DECIM_W(DECIM_W)) u_decim (
    .clk       (clk),
    .rst       (rst),
    .load      (start),
    .adc_valid (valid_w),
    .decim_q   (decim_q),
    .qualify   (qualify)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    start    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (empty_ok) begin
          settle_d = SET_W'(SETTLE_CYC - 1);
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!empty_ok) begin
          state_d = ST_IDLE;
        end else if (settle_q == '0) begin
          state_d = ST_WRITE;
          start   = 1'b1;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      ST_WRITE: begin
        if (fifo.full) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame datapath; a word still pending when full arrives is counted as dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decim_q     <= '0;
      word_cnt    <= '0;
      wr_pend     <= 1'b0;
      wrdata      <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_words <= '0;
      drop_cnt    <= '0;
    end else begin
      wr_pend    <= take;
      frame_done <= in_write && fifo.full;
      busy       <= (state_d == ST_SETTLE) || (state_d == ST_WRITE);
      if (take) wrdata <= adc_data;
      if (start) begin
        decim_q  <= decim;
        word_cnt <= '0;
        drop_cnt <= '0;
      end else begin
        if (wrreq && (word_cnt != '1)) word_cnt <= word_cnt + CNT_W'(1);
        if (wr_pend && fifo.full && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
      end
      if (in_write && fifo.full) frame_words <= word_cnt;
    end
  end

endmodule

// File: tb/tb_fifo_wr.sv
// Bench for fifo_wr: directed vector table, hand-written corner sequences, and a
// randomized run against a frame-level model with a depth-16 FIFO that drains only when full.
module tb_fifo_wr;

  localparam int unsigned DATA_W     = 9;
  localparam int unsigned SETTLE_CYC = 2;
  localparam int unsigned DECIM_W    = 16;
  localparam int unsigned CNT_W      = 10;
  localparam int          DEPTH      = 16;
  localparam int          CNT_MAX    = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic [DATA_W-1:0]  adc_data;
  logic               adc_valid;
  logic [DECIM_W-1:0] decim;
  logic               busy;
  logic               frame_done;
  logic [CNT_W-1:0]   frame_words;
  logic [7:0]         drop_cnt;

  fifo_wr_if #(.DATA_W(DATA_W)) fifo ();

  fifo_wr #(
    .DATA_W(DATA_W), .SETTLE_CYC(SETTLE_CYC), .DECIM_W(DECIM_W), .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .adc_data    (adc_data),
    .adc_valid   (adc_valid),
    .decim       (decim),
    .fifo        (fifo),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_words (frame_words),
    .drop_cnt    (drop_cnt)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: counts empty edges, indexes valid samples within the frame.
  int                m_run, m_k, m_dec, m_words, m_drop, m_fw, m_frames;
  bit                m_wr, m_hold, m_pend, m_fd;
  logic [DATA_W-1:0] m_wd;

  // FIFO environment state.
  bit fifo_mode = 1'b0;
  bit draining;
  bit pre_wr, pre_pop;
  int f_cnt, pushes, dut_frames;

  task automatic model_reset();
    m_run = 0; m_k = 0; m_dec = 0; m_words = 0; m_drop = 0; m_fw = 0;
    m_wr = 1'b0; m_hold = 1'b0; m_pend = 1'b0; m_fd = 1'b0; m_wd = '0;
  endtask

  task automatic model_edge();
    bit qual;
    m_fd = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_wr) begin
      if (m_pend && !fifo.full && m_words < CNT_MAX) m_words++;
      if (m_pend && fifo.full && m_drop < 255) m_drop++;
      m_pend = 1'b0;
      if (adc_valid) begin
        qual = ((m_k % (m_dec + 1)) == 0);
        if (qual && !fifo.full) begin
          m_pend = 1'b1;
          m_wd   = adc_data;
        end
        m_k++;
      end
      if (fifo.full) begin
        m_wr = 1'b0; m_fd = 1'b1; m_fw = m_words; m_hold = 1'b1;
        m_frames++;
        if (fifo_mode) chk("frame_pushes", pushes, DEPTH);
      end
    end else if (m_hold) begin
      m_hold = 1'b0;
    end else if (fifo.empty && !fifo.full) begin
      m_run++;
      if (m_run == int'(SETTLE_CYC) + 1) begin
        m_run = 0; m_wr = 1'b1; m_dec = int'(decim); m_k = 0;
        m_words = 0; m_drop = 0; pushes = 0;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic env_edge();
    if (pre_wr) begin
      chk("write_while_full", int'(f_cnt >= DEPTH), 0);
      f_cnt++;
      pushes++;
    end else if (draining && pre_pop && f_cnt > 0) begin
      f_cnt--;
    end
    if (rst) draining = 1'b1;
    if (f_cnt == DEPTH) draining = 1'b1;
    else if (f_cnt == 0) draining = 1'b0;
  endtask

  task automatic tick();
    #1;
    if (fifo_mode) begin
      pre_wr  = fifo.wrreq;
      pre_pop = ($urandom_range(0, 1) == 1);
    end
    @(posedge clk);
    model_edge();
    if (fifo_mode) env_edge();
    #1;
    if (fifo_mode) begin
      fifo.full  = (f_cnt == DEPTH);
      fifo.empty = (f_cnt == 0);
    end
    #1;
  endtask

  task automatic check_model();
    chk("rnd_wrreq", int'(fifo.wrreq), int'(m_pend && !fifo.full));
    chk("rnd_wrdata", int'(fifo.wrdata), int'(m_wd));
    chk("rnd_busy", int'(busy), int'(m_run > 0 || m_wr));
    chk("rnd_frame_done", int'(frame_done), int'(m_fd));
    chk("rnd_frame_words", int'(frame_words), m_fw);
    chk("rnd_drop_cnt", int'(drop_cnt), m_drop);
    if (frame_done) begin
      if (dut_frames == 0) chk("first_frame_words", int'(frame_words), DEPTH);
      dut_frames++;
    end
  endtask

  typedef struct {
    logic              rst, empty, full, valid;
    logic [DATA_W-1:0] data;
    logic [DECIM_W-1:0] dec;
    logic              busy, wrreq, fd;
    logic [DATA_W-1:0] wd;
    logic [CNT_W-1:0]  fw;
    logic [7:0]        drop;
  } vec_t;

  function automatic vec_t mk(int r, int e, int f, int v, int d, int dc,
                              int b, int w, int fd, int wd, int fw, int dr);
    vec_t x;
    x.rst = 1'(r); x.empty = 1'(e); x.full = 1'(f); x.valid = 1'(v);
    x.data = DATA_W'(d); x.dec = DECIM_W'(dc);
    x.busy = 1'(b); x.wrreq = 1'(w); x.fd = 1'(fd);
    x.wd = DATA_W'(wd); x.fw = CNT_W'(fw); x.drop = 8'(dr);
    return x;
  endfunction

  vec_t vecs[16];
  logic [DATA_W-1:0] ramp;

  initial begin
    rst = 1'b1; adc_data = '0; adc_valid = 1'b0; decim = '0;
    fifo.full = 1'b0; fifo.empty = 1'b0;
    draining = 1'b0; pre_wr = 1'b0; pre_pop = 1'b0;
    f_cnt = 0; pushes = 0; dut_frames = 0; m_frames = 0;
    model_reset();

    //             rst emp ful val dat dec | busy wrq fd  wd  fw drop
    vecs[0]  = mk(1,  0,  0,  0,  0,  0,    0,   0,  0,  0,  0, 0);
    vecs[1]  = mk(0,  1,  1,  0,  0,  0,    0,   0,  0,  0,  0, 0);
    vecs[2]  = mk(0,  1,  1,  0,  0,  0,    0,   0,  0,  0,  0, 0);
    vecs[3]  = mk(0,  1,  0,  0,  0,  0,    1,   0,  0,  0,  0, 0);
    vecs[4]  = mk(0,  0,  0,  0,  0,  0,    0,   0,  0,  0,  0, 0);
    vecs[5]  = mk(0,  0,  0,  0,  0,  0,    0,   0,  0,  0,  0, 0);
    vecs[6]  = mk(0,  1,  0,  1,  5,  0,    1,   0,  0,  0,  0, 0);
    vecs[7]  = mk(0,  1,  0,  1,  6,  0,    1,   0,  0,  0,  0, 0);
    vecs[8]  = mk(0,  1,  0,  1,  7,  0,    1,   0,  0,  0,  0, 0);
    vecs[9]  = mk(0,  0,  0,  1,  8,  0,    1,   1,  0,  8,  0, 0);
    vecs[10] = mk(0,  0,  0,  1,  9,  0,    1,   1,  0,  9,  0, 0);
    vecs[11] = mk(0,  0,  0,  0, 10,  0,    1,   0,  0,  9,  0, 0);
    vecs[12] = mk(0,  0,  0,  1, 11,  0,    1,   1,  0, 11,  0, 0);
    vecs[13] = mk(0,  0,  1,  1, 12,  0,    0,   0,  1, 11,  2, 1);
    vecs[14] = mk(0,  0,  1,  0,  0,  0,    0,   0,  0, 11,  2, 1);
    vecs[15] = mk(0,  1,  0,  0,  0,  0,    1,   0,  0, 11,  2, 1);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; fifo.empty = vecs[i].empty; fifo.full = vecs[i].full;
      adc_valid = vecs[i].valid; adc_data = vecs[i].data; decim = vecs[i].dec;
      tick();
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].busy));
      chk($sformatf("vec%0d_wrreq", i), int'(fifo.wrreq), int'(vecs[i].wrreq));
      chk($sformatf("vec%0d_wrdata", i), int'(fifo.wrdata), int'(vecs[i].wd));
      chk($sformatf("vec%0d_frame_done", i), int'(frame_done), int'(vecs[i].fd));
      chk($sformatf("vec%0d_frame_words", i), int'(frame_words), int'(vecs[i].fw));
      chk($sformatf("vec%0d_drop_cnt", i), int'(drop_cnt), int'(vecs[i].drop));
    end

    // Asynchronous reset while a word is pending.
    fifo.empty = 1'b1; adc_valid = 1'b0;
    tick();
    tick();
    fifo.empty = 1'b0; adc_valid = 1'b1; adc_data = DATA_W'(9'h55);
    tick();
    chk("rst_pre_wrreq", int'(fifo.wrreq), 1);
    rst = 1'b1;
    #1;
    chk("rst_wrreq", int'(fifo.wrreq), 0);
    chk("rst_wrdata", int'(fifo.wrdata), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_frame_words", int'(frame_words), 0);
    chk("rst_drop_cnt", int'(drop_cnt), 0);
    adc_valid = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_frame_done", int'(frame_done), 0);
      chk("post_rst_busy", int'(busy), 0);
      chk("post_rst_wrreq", int'(fifo.wrreq), 0);
    end

    // decim=3 spacing, with decim changed to 0 mid-frame.
    fifo.empty = 1'b1; decim = DECIM_W'(3);
    for (int i = 0; i < 3; i++) tick();
    fifo.empty = 1'b0;
    for (int k = 0; k < 16; k++) begin
      adc_valid = 1'b1; adc_data = DATA_W'(k);
      decim = DECIM_W'((k >= 6) ? 0 : 3);
      tick();
      chk($sformatf("decim_wrreq_s%0d", k), int'(fifo.wrreq), int'((k % 4) == 0));
      if ((k % 4) == 0) chk($sformatf("decim_wrdata_s%0d", k), int'(fifo.wrdata), k);
    end
    adc_valid = 1'b0; fifo.full = 1'b1;
    tick();
    chk("decim_frame_done", int'(frame_done), 1);
    chk("decim_frame_words", int'(frame_words), 4);
    chk("decim_drop_cnt", int'(drop_cnt), 0);
    fifo.full = 1'b0;
    tick();
    chk("decim_frame_done_low", int'(frame_done), 0);

    // Randomized run against the model with a FIFO that drains only once full.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    m_frames = 0; dut_frames = 0; f_cnt = 0; pushes = 0; draining = 1'b0;
    fifo.full = 1'b0; fifo.empty = 1'b1; fifo_mode = 1'b1;
    ramp = '0;
    for (int c = 0; c < 4000; c++) begin
      if (m_frames == 0) begin
        adc_valid = 1'b1;
        decim     = '0;
      end else begin
        adc_valid = ($urandom_range(0, 2) != 0);
        decim     = DECIM_W'($urandom_range(0, 3));
      end
      adc_data = ramp;
      ramp     = ramp + DATA_W'(1);
      rst      = (m_frames > 0) && ($urandom_range(0, 599) == 0);
      tick();
      check_model();
    end
    rst = 1'b0;
    chk("frame_count", dut_frames, m_frames);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
